// File: rtl/hippo_mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory.
// Round-robin grants with an optional per-port lock for atomic read-modify-write.
module hippo_mem_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             req_i,
  input  logic [1:0]             we_i,
  input  logic [1:0][ADDR_W-1:0] addr_i,
  input  logic [1:0][DATA_W-1:0] wdata_i,
  input  logic [1:0]             lock_i,
  output logic [1:0]             gnt_o,
  output logic [1:0]             rvalid_o,
  output logic [DATA_W-1:0]      rdata_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic                   mem_we_o,
  output logic [DATA_W-1:0]      mem_data_o,
  input  logic [DATA_W-1:0]      mem_data_i
);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t     state;
  logic       prio;
  logic [1:0] gnt;
  logic       sel;

  // Same-cycle grant; reset masks it immediately, independent of the clock.
  always_comb begin
    gnt = 2'b00;
    case (state)
      FREE: begin
        if (req_i == 2'b11) gnt = prio ? 2'b10 : 2'b01;
        else                gnt = req_i;
      end
      LOCK0:   gnt = {1'b0, req_i[0]};
      LOCK1:   gnt = {req_i[1], 1'b0};
      default: gnt = 2'b00;
    endcase
    if (rst_i) gnt = 2'b00;
  end

  assign sel   = gnt[1];
  assign gnt_o = gnt;

  // Memory port follows the granted requester, parked at zero when idle.
  always_comb begin
    mem_addr_o = '0;
    mem_we_o   = 1'b0;
    mem_data_o = '0;
    if (gnt != 2'b00) begin
      mem_addr_o = addr_i[sel];
      mem_we_o   = we_i[sel];
      mem_data_o = wdata_i[sel];
    end
  end

  // Memory returns data one cycle after the address, aligned with rvalid_o.
  assign rdata_o = mem_data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= FREE;
      prio     <= 1'b0;
      rvalid_o <= 2'b00;
    end else begin
      rvalid_o <= gnt & ~we_i;
      case (state)
        FREE: begin
          if (gnt != 2'b00) begin
            prio <= ~sel;
            if (lock_i[sel]) state <= sel ? LOCK1 : LOCK0;
          end
        end
        // Lock is released on the first edge that samples lock low; prio then hands over.
        LOCK0: begin
          if (!lock_i[0]) begin
            state <= FREE;
            prio  <= 1'b1;
          end
        end
        LOCK1: begin
          if (!lock_i[1]) begin
            state <= FREE;
            prio  <= 1'b0;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_hippo_mem_arbiter.sv
// Bench for hippo_mem_arbiter: scripted cycles with expected grants, plus a read-data
// scoreboard fed from a shadow copy of memory.
module tb_hippo_mem_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req, we, lock;
  logic [1:0][9:0]  addr;
  logic [1:0][7:0]  wdata;
  logic [1:0]       gnt, rvalid;
  logic [7:0]       rdata;
  logic [9:0]       mem_addr;
  logic             mem_we;
  logic [7:0]       mem_wdata;
  logic [7:0]       mem_rdata;

  logic [7:0] mem    [0:1023];
  logic [7:0] shadow [0:1023];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int checks = 0;
  int errors = 0;
  int g0, g1;

  always #5 clk = ~clk;

  hippo_mem_arbiter #(.ADDR_W(10), .DATA_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .lock_i(lock), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_data_o(mem_wdata), .mem_data_i(mem_rdata)
  );

  // Single-port synchronous memory with one-cycle read latency.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive at negedge, check 1 time unit later, then update the scoreboard.
  task automatic cyc(input string tag, input logic [1:0] r, input logic [1:0] w,
                     input logic [1:0] lk, input logic [9:0] a0, input logic [9:0] a1,
                     input logic [7:0] d0, input logic [7:0] d1,
                     input logic [1:0] egnt, input logic [1:0] erv);
    logic [1:0][9:0] a;
    logic [1:0][7:0] d;
    int n;
    @(negedge clk);
    req = r; we = w; lock = lk;
    addr[0] = a0; addr[1] = a1; wdata[0] = d0; wdata[1] = d1;
    a = addr; d = wdata;
    #1;
    check({tag, "_gnt"}, 32'(gnt), 32'(egnt));
    check({tag, "_rv"}, 32'(rvalid), 32'(erv));
    if (egnt != 2'b00) begin
      n = egnt[1] ? 1 : 0;
      check({tag, "_maddr"}, 32'(mem_addr), 32'(a[n]));
      check({tag, "_mwe"}, 32'(mem_we), 32'(w[n]));
      check({tag, "_mdata"}, 32'(mem_wdata), 32'(d[n]));
    end else begin
      check({tag, "_idle"}, {22'(mem_addr), 1'(mem_we), 8'(mem_wdata), 1'b0}, 32'd0);
    end
    if (rvalid[0]) begin
      if (q0.size() == 0) check({tag, "_rv0_unexp"}, 32'd1, 32'd0);
      else check({tag, "_rd0"}, 32'(rdata), 32'(q0.pop_front()));
    end
    if (rvalid[1]) begin
      if (q1.size() == 0) check({tag, "_rv1_unexp"}, 32'd1, 32'd0);
      else check({tag, "_rd1"}, 32'(rdata), 32'(q1.pop_front()));
    end
    if (egnt[0] && !w[0]) q0.push_back(shadow[a0]);
    if (egnt[0] &&  w[0]) shadow[a0] = d0;
    if (egnt[1] && !w[1]) q1.push_back(shadow[a1]);
    if (egnt[1] &&  w[1]) shadow[a1] = d1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = 8'(i * 7 + 3);
      shadow[i] = 8'(i * 7 + 3);
    end
    rst = 1'b1; req = 2'b11; we = 2'b00; lock = 2'b00;
    addr = '0; wdata = '0;
    #3;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rv", 32'(rvalid), 32'd0);
    check("rst_mwe", 32'(mem_we), 32'd0);
    @(posedge clk);
    @(posedge clk);
    req = 2'b00;
    #2 rst = 1'b0;

    // Both read, priority starts at port 0.
    cyc("c1", 2'b11, 2'b00, 2'b00, 10'h005, 10'h006, 8'h00, 8'h00, 2'b01, 2'b00);
    cyc("c2", 2'b10, 2'b00, 2'b00, 10'h005, 10'h006, 8'h00, 8'h00, 2'b10, 2'b01);
    cyc("c3", 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 2'b10);
    // Port 1 writes, port 0 reads it back.
    cyc("c4", 2'b10, 2'b10, 2'b00, 10'h000, 10'h010, 8'h00, 8'hA7, 2'b10, 2'b00);
    cyc("c5", 2'b01, 2'b00, 2'b00, 10'h010, 10'h000, 8'h00, 8'h00, 2'b01, 2'b00);
    cyc("c6", 2'b10, 2'b00, 2'b00, 10'h000, 10'h033, 8'h00, 8'h00, 2'b10, 2'b01);

    // Continuous contention: strict alternation.
    g0 = 0; g1 = 0;
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("rr%0d", i), 2'b11, 2'b00, 2'b00, 10'(10'h100 + i / 2),
          10'(10'h180 + i / 2), 8'h00, 8'h00, (i % 2 == 0) ? 2'b01 : 2'b10,
          (i % 2 == 0) ? 2'b10 : 2'b01);
      g0 += int'(gnt[0]);
      g1 += int'(gnt[1]);
    end
    check("rr_cnt0", 32'(g0), 32'd4);
    check("rr_cnt1", 32'(g1), 32'd4);
    cyc("rr_end", 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 2'b10);

    // Atomic RMW on port 0 while port 1 waits.
    cyc("d1", 2'b11, 2'b00, 2'b01, 10'h020, 10'h020, 8'h00, 8'h00, 2'b01, 2'b00);
    cyc("d2", 2'b10, 2'b00, 2'b01, 10'h020, 10'h020, 8'h00, 8'h00, 2'b00, 2'b01);
    cyc("d3", 2'b11, 2'b01, 2'b00, 10'h020, 10'h020, 8'h21, 8'h00, 2'b01, 2'b00);
    cyc("d4", 2'b10, 2'b00, 2'b00, 10'h000, 10'h020, 8'h00, 8'h00, 2'b10, 2'b00);
    cyc("d5", 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 2'b10);
    check("d_val", 32'(shadow[10'h020]), 32'h21);

    // Asynchronous reset in the middle of a granted read.
    cyc("r1", 2'b01, 2'b00, 2'b00, 10'h007, 10'h000, 8'h00, 8'h00, 2'b01, 2'b00);
    cyc("r2", 2'b01, 2'b00, 2'b00, 10'h008, 10'h000, 8'h00, 8'h00, 2'b01, 2'b01);
    #2 rst = 1'b1;
    #1;
    check("ar_gnt", 32'(gnt), 32'd0);
    check("ar_rv", 32'(rvalid), 32'd0);
    check("ar_mwe", 32'(mem_we), 32'd0);
    q0.delete();
    q1.delete();
    req = 2'b00;
    @(posedge clk);
    #2 rst = 1'b0;
    cyc("p1", 2'b11, 2'b00, 2'b00, 10'h009, 10'h00A, 8'h00, 8'h00, 2'b01, 2'b00);
    cyc("p2", 2'b10, 2'b00, 2'b00, 10'h000, 10'h00A, 8'h00, 8'h00, 2'b10, 2'b01);
    cyc("p3", 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 2'b10);
    // Port 1 lock: port 0 blocked until the lock drops, even without a port-1 request.
    cyc("p4", 2'b10, 2'b00, 2'b10, 10'h000, 10'h030, 8'h00, 8'h00, 2'b10, 2'b00);
    cyc("p5", 2'b11, 2'b10, 2'b10, 10'h030, 10'h030, 8'h00, 8'h99, 2'b10, 2'b10);
    cyc("p6", 2'b01, 2'b00, 2'b00, 10'h030, 10'h000, 8'h00, 8'h00, 2'b00, 2'b00);
    cyc("p7", 2'b01, 2'b00, 2'b00, 10'h030, 10'h000, 8'h00, 8'h00, 2'b01, 2'b00);
    cyc("p8", 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 2'b01);

    check("q0_empty", 32'(q0.size()), 32'd0);
    check("q1_empty", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
